pcpi_div_param: RTL and testbench

Parametrised iterative PCPI divide/remainder coprocessor for RV32M/RV64M DIV, DIVU, REM, REMU, plus the RV64 word forms (DIVW, DIVUW, REMW, REMUW).
- Attaches to the core's PCPI bus alongside the multiplier.
- Configurable datapath width and radix: 1, 2 or 4 quotient bits per cycle.
- Supports requester abort: the operation is cancelled if pcpi_valid drops mid-operation.

---
 rtl/pcpi_div_pkg.sv | 20 ++
 rtl/pcpi_div_step.sv | 34 +++
 rtl/pcpi_div_param.sv | 189 ++++++++++++++++++
 tb/tb_pcpi_div_param.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_div_pkg.sv
// Shared types and encodings for the PCPI divide/remainder coprocessor.
package pcpi_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        RUN,
        DONE
    } state_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP32      = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/pcpi_div_step.sv
// Combinational restoring-division slice: retires BITS_PER_CYCLE quotient bits, MSB first.
module pcpi_div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    always_comb begin
        logic [XLEN:0]   sh;
        logic            ge;
        logic [XLEN-1:0] rem_v;
        logic [XLEN-1:0] quo_v;
        rem_v = rem_i;
        quo_v = quo_i;
        sh    = '0;
        ge    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            // Shift the next dividend bit into the partial remainder, keep the
            // subtraction only if it does not borrow.
            sh    = {rem_v, quo_v[XLEN-1]};
            ge    = (sh >= {1'b0, dvs_i});
            rem_v = ge ? (sh[XLEN-1:0] - dvs_i) : sh[XLEN-1:0];
            quo_v = {quo_v[XLEN-2:0], ge};
        end
        rem_o = rem_v;
        quo_o = quo_v;
    end

endmodule

// File: rtl/pcpi_div_param.sv
// Iterative PCPI DIV/DIVU/REM/REMU (+ RV64 W-forms) coprocessor.
// Define PCPI_DIV_FAST_SPECIAL_EN to short-circuit trivial divides straight to DONE.
module pcpi_div_param
    import pcpi_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready,
    output logic            busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            is_div_q, is_div_d;
    logic            is_sgn_q, is_sgn_d;
    logic            is_w_q, is_w_d;
    logic            outsign_q, outsign_d;
    logic            done_q;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       match;
    logic       unused_insn;

    assign opcode      = pcpi_insn[6:0];
    assign funct3      = pcpi_insn[14:12];
    assign funct7      = pcpi_insn[31:25];
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
    assign match       = (funct7 == FUNCT7_MULDIV) && funct3[2] &&
                         ((opcode == OPC_OP) || ((XLEN == 64) && (opcode == OPC_OP32)));

    // Operand preparation (valid in DECODE: flags are latched, operands stable).
    logic [XLEN-1:0] op1, op2, mag1, mag2;
    logic            neg1, neg2;

    always_comb begin
        op1 = pcpi_rs1;
        op2 = pcpi_rs2;
        if (is_w_q) begin
            op1 = is_sgn_q ? XLEN'($signed(pcpi_rs1[31:0])) : XLEN'(pcpi_rs1[31:0]);
            op2 = is_sgn_q ? XLEN'($signed(pcpi_rs2[31:0])) : XLEN'(pcpi_rs2[31:0]);
        end
        neg1 = is_sgn_q && op1[XLEN-1];
        neg2 = is_sgn_q && op2[XLEN-1];
        mag1 = neg1 ? -op1 : op1;
        mag2 = neg2 ? -op2 : op2;
    end

`ifdef PCPI_DIV_FAST_SPECIAL_EN
    logic [XLEN-1:0] min_val;
    logic            ovf;
    assign min_val = is_w_q ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    assign ovf     = is_sgn_q && (op2 == '1) && (op1 == min_val);
`endif

    logic [XLEN-1:0] step_rem, step_quo;

    pcpi_div_step #(
        .XLEN          (XLEN),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_div_d  = is_div_q;
        is_sgn_d  = is_sgn_q;
        is_w_d    = is_w_q;
        outsign_d = outsign_q;
        unique case (state_q)
            IDLE: begin
                // done_q blocks a relaunch while the core still holds valid after ready.
                if (pcpi_valid && match && !done_q) begin
                    state_d  = DECODE;
                    is_div_d = (funct3 == F3_DIV) || (funct3 == F3_DIVU);
                    is_sgn_d = (funct3 == F3_DIV) || (funct3 == F3_REM);
                    is_w_d   = (XLEN == 64) && (opcode == OPC_OP32);
                end
            end
            DECODE: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else begin
                    rem_d     = '0;
                    quo_d     = mag1;
                    dvs_d     = mag2;
                    outsign_d = is_div_q ? (neg1 ^ neg2) && (op2 != '0) : neg1;
                    cnt_d     = CW'(N - 1);
                    state_d   = RUN;
`ifdef PCPI_DIV_FAST_SPECIAL_EN
                    if (op2 == '0) begin
                        quo_d   = '1;
                        rem_d   = mag1;
                        state_d = DONE;
                    end else if (ovf) begin
                        quo_d   = mag1;
                        rem_d   = '0;
                        state_d = DONE;
                    end else if (mag1 < mag2) begin
                        quo_d   = '0;
                        rem_d   = mag1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_div_q  <= 1'b0;
            is_sgn_q  <= 1'b0;
            is_w_q    <= 1'b0;
            outsign_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            is_div_q  <= is_div_d;
            is_sgn_q  <= is_sgn_d;
            is_w_q    <= is_w_d;
            outsign_q <= outsign_d;
            done_q    <= (state_q == DONE);
        end
    end

    logic [XLEN-1:0] raw_res, sgn_res, result;

    always_comb begin
        raw_res = is_div_q ? quo_q : rem_q;
        sgn_res = outsign_q ? -raw_res : raw_res;
        // W-forms always sign-extend the 32-bit result, unsigned ones included.
        result  = is_w_q ? XLEN'($signed(sgn_res[31:0])) : sgn_res;
    end

    assign pcpi_ready = (state_q == DONE);
    assign pcpi_wr    = pcpi_ready;
    assign pcpi_rd    = pcpi_ready ? result : '0;
    assign pcpi_wait  = (state_q == DECODE) || (state_q == RUN);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pcpi_div_param.sv
// Self-checking bench: three DUT configurations (32/1, 32/4, 64/2) driven by a scoreboard.
module tb_pcpi_div_param;
    import pcpi_div_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] insn = '0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic        vld [3];
    logic [31:0] rd_a, rd_b;
    logic [63:0] rd_c;
    logic        wr_o [3], rdy [3], wt [3], bsy [3];
    logic [63:0] rd_o [3];
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        int          d;
        logic [63:0] rd;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct packed {
        logic [1:0]  d;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } vec_t;

    always #5 clk = ~clk;

    pcpi_div_param #(.XLEN(32), .BITS_PER_CYCLE(1)) u_d0 (
        .clk(clk), .resetn(resetn), .pcpi_valid(vld[0]), .pcpi_insn(insn),
        .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wr_o[0]), .pcpi_rd(rd_a),
        .pcpi_wait(wt[0]), .pcpi_ready(rdy[0]), .busy(bsy[0]));
    pcpi_div_param #(.XLEN(32), .BITS_PER_CYCLE(4)) u_d1 (
        .clk(clk), .resetn(resetn), .pcpi_valid(vld[1]), .pcpi_insn(insn),
        .pcpi_rs1(rs1[31:0]), .pcpi_rs2(rs2[31:0]), .pcpi_wr(wr_o[1]), .pcpi_rd(rd_b),
        .pcpi_wait(wt[1]), .pcpi_ready(rdy[1]), .busy(bsy[1]));
    pcpi_div_param #(.XLEN(64), .BITS_PER_CYCLE(2)) u_d2 (
        .clk(clk), .resetn(resetn), .pcpi_valid(vld[2]), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_o[2]), .pcpi_rd(rd_c),
        .pcpi_wait(wt[2]), .pcpi_ready(rdy[2]), .busy(bsy[2]));

    assign rd_o[0] = {32'd0, rd_a};
    assign rd_o[1] = {32'd0, rd_b};
    assign rd_o[2] = rd_c;

    function automatic logic [31:0] mk(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference result from native arithmetic; 32-bit units and W-forms work on the low word.
    function automatic logic [63:0] model(int d, logic [2:0] f3, bit w, logic [63:0] a, logic [63:0] b);
        bit                 half;
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, r;
        half = (d != 2) || w;
        if (half) begin
            sa = {{32{a[31]}}, a[31:0]};
            sb = {{32{b[31]}}, b[31:0]};
            ua = {32'd0, a[31:0]};
            ub = {32'd0, b[31:0]};
        end else begin
            sa = a; sb = b; ua = a; ub = b;
        end
        r = '0;
        case (f3)
            F3_DIV:  if (ub == 0) r = '1; else if (sb == -1) r = -sa; else r = sa / sb;
            F3_REM:  if (ub == 0) r = sa; else if (sb == -1) r = '0; else r = sa % sb;
            F3_DIVU: if (ub == 0) r = '1; else r = ua / ub;
            default: if (ub == 0) r = ua; else r = ua % ub;
        endcase
        if (d == 2 && !w) return r;
        if (d == 2) return {{32{r[31]}}, r[31:0]};
        return {32'd0, r[31:0]};
    endfunction

    function automatic int exp_lat(int d, logic [2:0] f3, bit w, logic [63:0] a, logic [63:0] b);
        int n;
        n = (d == 1) ? 8 : 32;
`ifdef PCPI_DIV_FAST_SPECIAL_EN
        begin
            bit          sgn, half;
            logic [63:0] ea, eb, ma, mb, mn;
            sgn  = (f3 == F3_DIV) || (f3 == F3_REM);
            half = (d != 2) || w;
            if (half) begin
                ea = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
                eb = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
                mn = 64'hFFFF_FFFF_8000_0000;
            end else begin
                ea = a; eb = b;
                mn = 64'h8000_0000_0000_0000;
            end
            ma = (sgn && ea[63]) ? -ea : ea;
            mb = (sgn && eb[63]) ? -eb : eb;
            if (eb == 0 || (sgn && eb == '1 && ea == mn) || ma < mb) return 2;
        end
`endif
        return 2 + n;
    endfunction

    // Issue one op and wait (bounded) for ready; lat counts cycles from the valid cycle.
    task automatic do_op(input int d, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] rd, output logic wr, output int lat);
        @(posedge clk); #1;
        insn = ins; rs1 = a; rs2 = b; vld[d] = 1'b1;
        lat = -1; rd = '0; wr = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rdy[d]) begin
                lat = k; rd = rd_o[d]; wr = wr_o[d];
                break;
            end
        end
        @(posedge clk); #1;
        vld[d] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if ({rdy[d], wr_o[d], wt[d], bsy[d]} !== 4'b0000 || rd_o[d] !== 64'd0) begin
                n_bad++;
                $display("FAIL reset d%0d: ready/wr/wait/busy=%b%b%b%b rd=%h, want all 0", d,
                         rdy[d], wr_o[d], wt[d], bsy[d], rd_o[d]);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_vectors();
        vec_t        v [13];
        exp_t        e;
        logic [63:0] rd;
        logic        wr;
        int          lat;
        v = '{
            '{2'd0, F3_DIV,  1'b0, 64'd20,               64'hFFFF_FFFD,          64'hFFFF_FFFA},
            '{2'd0, F3_REM,  1'b0, 64'd20,               64'hFFFF_FFFD,          64'd2},
            '{2'd0, F3_DIVU, 1'b0, 64'd5,                64'd0,                  64'hFFFF_FFFF},
            '{2'd0, F3_REM,  1'b0, 64'hFFFF_FFF9,        64'd0,                  64'hFFFF_FFF9},
            '{2'd0, F3_DIV,  1'b0, 64'h8000_0000,        64'hFFFF_FFFF,          64'h8000_0000},
            '{2'd0, F3_REM,  1'b0, 64'h8000_0000,        64'hFFFF_FFFF,          64'd0},
            '{2'd1, F3_REMU, 1'b0, 64'd100,              64'd7,                  64'd2},
            '{2'd1, F3_DIV,  1'b0, 64'd7,                64'd9,                  64'd0},
            '{2'd2, F3_DIV,  1'b1, 64'h1_FFFF_FFF0,      64'd3,                  64'hFFFF_FFFF_FFFF_FFFB},
            '{2'd2, F3_DIVU, 1'b1, 64'd5,                64'd0,                  64'hFFFF_FFFF_FFFF_FFFF},
            '{2'd2, F3_REMU, 1'b1, 64'hABCD_0000_8000_0001, 64'd0,               64'hFFFF_FFFF_8000_0001},
            '{2'd2, F3_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000},
            '{2'd2, F3_REM,  1'b1, 64'h8000_0000,        64'hFFFF_FFFF,          64'd0}
        };
        foreach (v[i]) begin
            sbq.push_back(exp_t'{int'(v[i].d), v[i].r, exp_lat(int'(v[i].d), v[i].f3, v[i].w, v[i].a, v[i].b)});
            do_op(int'(v[i].d), mk(FUNCT7_MULDIV, v[i].f3, v[i].w ? OPC_OP32 : OPC_OP), v[i].a, v[i].b, rd, wr, lat);
            e = sbq.pop_front();
            n_cmp++;
            if (rd !== e.rd) begin
                n_bad++;
                $display("FAIL vec%0d rd: got %h want %h", i, rd, e.rd);
            end
            n_cmp++;
            if (wr !== 1'b1 || lat != e.lat) begin
                n_bad++;
                $display("FAIL vec%0d timing: wr=%b lat=%0d want wr=1 lat=%0d", i, wr, lat, e.lat);
            end
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [63:0] a, b, rd;
        logic [2:0]  f3;
        logic        wr;
        bit          w;
        int          lat;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 8; k++) begin
                f3 = 3'(4 + $urandom_range(0, 3));
                w  = (d == 2) && ($urandom_range(0, 1) == 1);
                a  = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       b = 64'($urandom_range(0, 15));
                    1:       b = '1;
                    2:       b = {$urandom, $urandom} >> $urandom_range(0, 60);
                    default: b = {$urandom, $urandom};
                endcase
                if ($urandom_range(0, 3) == 0)
                    a = (d == 2 && !w) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
                sbq.push_back(exp_t'{d, model(d, f3, w, a, b), exp_lat(d, f3, w, a, b)});
                do_op(d, mk(FUNCT7_MULDIV, f3, w ? OPC_OP32 : OPC_OP), a, b, rd, wr, lat);
                e = sbq.pop_front();
                n_cmp++;
                if (rd !== e.rd || wr !== 1'b1 || lat != e.lat) begin
                    n_bad++;
                    $display("FAIL rand d%0d f3=%b w=%b a=%h b=%h: rd=%h wr=%b lat=%0d want rd=%h lat=%0d",
                             d, f3, w, a, b, rd, wr, lat, e.rd, e.lat);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd [4];
        logic        wr [4];
        int          lat [4];
        logic [63:0] a [4] = '{64'd1000, 64'hFFFF_FC18, 64'd77, 64'd3};
        logic [63:0] b [4] = '{64'd7, 64'd7, 64'hFFFF_FFF6, 64'd3};
        logic [2:0]  f [4] = '{F3_DIVU, F3_DIV, F3_REM, F3_REMU};
        exp_t        e;
        for (int i = 0; i < 4; i++) sbq.push_back(exp_t'{0, model(0, f[i], 1'b0, a[i], b[i]), exp_lat(0, f[i], 1'b0, a[i], b[i])});
        for (int i = 0; i < 4; i++) do_op(0, mk(FUNCT7_MULDIV, f[i], OPC_OP), a[i], b[i], rd[i], wr[i], lat[i]);
        for (int i = 0; i < 4; i++) begin
            e = sbq.pop_front();
            n_cmp++;
            if (rd[i] !== e.rd || wr[i] !== 1'b1 || lat[i] != e.lat) begin
                n_bad++;
                $display("FAIL b2b%0d: rd=%h lat=%0d want rd=%h lat=%0d", i, rd[i], lat[i], e.rd, e.lat);
            end
        end
    endtask

    task automatic test_no_relaunch();
        int lat;
        @(posedge clk); #1;
        insn = mk(FUNCT7_MULDIV, F3_DIVU, OPC_OP); rs1 = 64'd50; rs2 = 64'd6; vld[0] = 1'b1;
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rdy[0]) begin lat = k; break; end
        end
        n_cmp++;
        if (lat != exp_lat(0, F3_DIVU, 1'b0, 64'd50, 64'd6)) begin
            n_bad++;
            $display("FAIL relaunch lat: got %0d want %0d", lat, exp_lat(0, F3_DIVU, 1'b0, 64'd50, 64'd6));
        end
        // Valid stays up through the IDLE cycle that follows DONE.
        @(posedge clk);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bsy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL relaunch busy: got %b want 0", bsy[0]);
        end
    endtask

    task automatic test_abort();
        bit          seen;
        exp_t        e;
        logic [63:0] rd;
        logic        wr;
        int          lat;
        @(posedge clk); #1;
        insn = mk(FUNCT7_MULDIV, F3_DIV, OPC_OP); rs1 = 64'd100; rs2 = 64'd7; vld[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rdy[0] || wr_o[0]) seen = 1'b1;
        end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (wt[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort state T+6: wait=%b busy=%b want 0 0", wt[0], bsy[0]);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy[0] || wr_o[0]) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL abort pulse: ready/wr seen=1 want 0");
        end
        sbq.push_back(exp_t'{0, 64'd4, exp_lat(0, F3_DIVU, 1'b0, 64'd9, 64'd2)});
        do_op(0, mk(FUNCT7_MULDIV, F3_DIVU, OPC_OP), 64'd9, 64'd2, rd, wr, lat);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd || wr !== 1'b1 || lat != e.lat) begin
            n_bad++;
            $display("FAIL after-abort divu: rd=%h lat=%0d want rd=%h lat=%0d", rd, lat, e.rd, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [63:0] rd;
        logic        wr;
        int          lat;
        @(posedge clk); #1;
        insn = mk(FUNCT7_MULDIV, F3_DIV, OPC_OP); rs1 = 64'd12345; rs2 = 64'd11; vld[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rdy[0], wr_o[0], wt[0], bsy[0]} !== 4'b0000 || rd_o[0] !== 64'd0) begin
            n_bad++;
            $display("FAIL reset-mid: ready/wr/wait/busy=%b%b%b%b rd=%h want 0", rdy[0], wr_o[0], wt[0], bsy[0], rd_o[0]);
        end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        resetn = 1'b1;
        sbq.push_back(exp_t'{0, model(0, F3_REM, 1'b0, 64'd12345, 64'd11), exp_lat(0, F3_REM, 1'b0, 64'd12345, 64'd11)});
        do_op(0, mk(FUNCT7_MULDIV, F3_REM, OPC_OP), 64'd12345, 64'd11, rd, wr, lat);
        e = sbq.pop_front();
        n_cmp++;
        if (rd !== e.rd || wr !== 1'b1 || lat != e.lat) begin
            n_bad++;
            $display("FAIL after-reset rem: rd=%h lat=%0d want rd=%h lat=%0d", rd, lat, e.rd, e.lat);
        end
    endtask

    task automatic test_non_m();
        int          dsel [3] = '{2, 0, 0};
        logic [31:0] ins  [3];
        bit          seen;
        ins[0] = mk(7'b0000000, 3'b100, OPC_OP);
        ins[1] = mk(FUNCT7_MULDIV, 3'b000, OPC_OP);
        ins[2] = mk(FUNCT7_MULDIV, F3_DIV, OPC_OP32);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            insn = ins[i]; rs1 = 64'd9; rs2 = 64'd3; vld[dsel[i]] = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (wt[dsel[i]] || bsy[dsel[i]] || rdy[dsel[i]]) seen = 1'b1;
            end
            @(posedge clk); #1;
            vld[dsel[i]] = 1'b0;
            n_cmp++;
            if (seen) begin
                n_bad++;
                $display("FAIL non-m%0d: wait/busy/ready went high, want 0", i);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_no_relaunch();
        test_abort();
        test_reset_mid();
        test_non_m();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
